// File: rtl/ising_run_controller.sv
// Run sequencer for a coupled ring-oscillator Ising array: owns the coupling
// weight bank, releases the array, measures phase mismatch vs oscillator 0, reports spins.
module ising_run_controller #(
   parameter int N              = 4,
   parameter int SETTLE_CYCLES  = 64,
   parameter int MEASURE_CYCLES = 256,
   parameter int CNT_W          = 9,
   localparam int AW = (N > 1) ? $clog2(N*N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [AW-1:0]      wr_addr,
   input  logic [2:0]         wr_data,
   output logic               wr_err,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       spins,
   output logic               osc_rstn,
   output logic [3*N*N-1:0]   weights_flat,
   input  logic [N-1:0]       osc_out,
   output logic [1:0]         dbg_state_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_MEASURE = 2'd2;
   localparam logic [1:0] S_DECIDE  = 2'd3;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [1:0]        state_q, state_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [CNT_W-1:0]  meas_q, meas_d;
   logic [CNT_W-1:0]  cnt_q [N];
   logic [CNT_W-1:0]  cnt_d [N];
   logic [N-1:0]      spins_q, spins_d;
   logic [N-1:0]      sync1_q, sync2_q;
   logic [3*N*N-1:0]  weights_q;
   logic              wr_err_q;
   logic              addr_ok, wr_fire, wr_bad;

   // Handshake: a write transfers in any cycle where wr_valid && wr_ready;
   // wr_ready is high only in IDLE, so the bank never changes during a run.
   assign wr_ready = (state_q == S_IDLE);
   assign wr_fire  = wr_valid && wr_ready;
   assign wr_bad   = !addr_ok || (wr_data > 3'd4);

   if ((1 << AW) == N*N) begin : g_full_addr
      assign addr_ok = 1'b1;
   end else begin : g_part_addr
      assign addr_ok = (wr_addr < AW'(N*N));
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      meas_d   = meas_q;
      cnt_d    = cnt_q;
      spins_d  = spins_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
               state_d = S_MEASURE;
               meas_d  = '0;
               for (int i = 0; i < N; i++) cnt_d[i] = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_MEASURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               for (int i = 1; i < N; i++) begin
                  if ((sync2_q[i] != sync2_q[0]) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
               end
               cnt_d[0] = '0;
               // Spins resolve on the final sample so they are valid alongside done.
               if (meas_q == CNT_W'(MEASURE_CYCLES - 1)) begin
                  state_d = S_DECIDE;
                  for (int i = 0; i < N; i++) spins_d[i] = (cnt_d[i] > CNT_W'(MEASURE_CYCLES / 2));
                  spins_d[0] = 1'b0;
               end else begin
                  meas_d = meas_q + 1'b1;
               end
            end
         end
         default: begin
            if (start) begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         settle_q  <= '0;
         meas_q    <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
         spins_q   <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         weights_q <= {(N*N){3'b010}};
         wr_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         meas_q   <= meas_d;
         cnt_q    <= cnt_d;
         spins_q  <= spins_d;
         sync1_q  <= osc_out;
         sync2_q  <= sync1_q;
         wr_err_q <= wr_fire && wr_bad;
         if (wr_fire && !wr_bad) weights_q[3*int'(wr_addr) +: 3] <= wr_data;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DECIDE);
   assign osc_rstn     = (state_q == S_SETTLE) || (state_q == S_MEASURE);
   assign wr_err       = wr_err_q;
   assign spins        = spins_q;
   assign weights_flat = weights_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ising_run_controller.sv
// Bench for ising_run_controller: phase-pattern oscillator model, weight bank model,
// and a spin scoreboard drained by an independent done monitor.
module tb_ising_run_controller;
   localparam int N  = 4;
   localparam int S  = 4;
   localparam int M  = 8;
   localparam int CW = 9;
   localparam int AW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [AW-1:0]     wr_addr = '0;
   logic [2:0]        wr_data = '0;
   logic              wr_err;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              busy, done, osc_rstn;
   logic [N-1:0]      spins;
   logic [3*N*N-1:0]  weights_flat;
   logic [N-1:0]      osc_out = '0;
   logic [1:0]        dbg_state;

   // Small N=3 instance: its 4-bit address can reach beyond the 9-entry bank.
   logic              w3_valid = 1'b0;
   logic [3:0]        w3_addr = '0;
   logic [2:0]        w3_data = '0;
   logic              w3_ready, w3_err, busy3, done3, osc_rstn3;
   logic [2:0]        spins3;
   logic [26:0]       weights3, exp3;
   logic [1:0]        dbg3;
   logic              tie0 = 1'b0;
   logic [2:0]        osc3 = '0;

   ising_run_controller #(.N(N), .SETTLE_CYCLES(S), .MEASURE_CYCLES(M), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .start(start), .abort(abort), .busy(busy),
      .done(done), .spins(spins), .osc_rstn(osc_rstn), .weights_flat(weights_flat),
      .osc_out(osc_out), .dbg_state_o(dbg_state));

   ising_run_controller #(.N(3), .SETTLE_CYCLES(2), .MEASURE_CYCLES(4), .CNT_W(3)) u_dut3 (
      .clk(clk), .rst(rst), .wr_valid(w3_valid), .wr_ready(w3_ready), .wr_addr(w3_addr),
      .wr_data(w3_data), .wr_err(w3_err), .start(tie0), .abort(tie0), .busy(busy3),
      .done(done3), .spins(spins3), .osc_rstn(osc_rstn3), .weights_flat(weights3),
      .osc_out(osc3), .dbg_state_o(dbg3));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int phase    = 0;
   logic osc0;
   logic [N-1:0] exp_q[$];
   logic [2:0]   model_w [N*N];
   logic [3:0]   mask [N];

   always @(posedge clk) cyc <= cyc + 1;

   // Oscillator i = osc0 XOR a period-4 mismatch mask, so any window of M=8
   // samples holds exactly 2*popcount(mask) mismatches regardless of alignment.
   always begin
      @(posedge clk);
      #2;
      phase = (phase + 1) % 4;
      osc0  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) osc_out[i] = (i == 0) ? osc0 : (osc0 ^ mask[i][phase]);
   end

   always begin
      @(posedge clk);
      #1;
      if (!rst && done) begin
         logic [N-1:0] e;
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: spins=%b with no run expected", spins);
         end else begin
            e = exp_q.pop_front();
            if (spins !== e) begin
               failures++;
               $display("FAIL spins: got %b expected %b", spins, e);
            end
         end
      end
   end

   function automatic logic [N-1:0] model_spins();
      logic [N-1:0] s = '0;
      for (int i = 1; i < N; i++) begin
         int mism = $countones(mask[i]) * (M / 4);
         s[i] = (mism > M / 2);
      end
      return s;
   endfunction

   function automatic logic [3*N*N-1:0] model_flat();
      logic [3*N*N-1:0] f;
      for (int e = 0; e < N*N; e++) f[3*e +: 3] = model_w[e];
      return f;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int addr, input int data);
      wr_valid = 1'b1;
      wr_addr  = AW'(addr);
      wr_data  = 3'(data);
      check("wr_ready_idle", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      if (data <= 4) model_w[addr] = 3'(data);
      check("wr_err", wr_err, (data > 4) ? 1 : 0);
      check("weights", weights_flat, model_flat());
      tick();
      check("wr_err_clear", wr_err, 0);
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      check("done_seen", (dcyc >= 0) ? 1 : 0, 1);
   endtask

   task automatic set_masks(input logic [3:0] m1, input logic [3:0] m2, input logic [3:0] m3);
      mask[1] = m1;
      mask[2] = m2;
      mask[3] = m3;
   endtask

   initial begin
      int t, d, d0, d1, d2, seen;
      for (int i = 0; i < N; i++) mask[i] = '0;
      for (int e = 0; e < N*N; e++) model_w[e] = 3'b010;
      for (int e = 0; e < 9; e++) exp3[3*e +: 3] = 3'b010;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_weights", weights_flat, model_flat());
      check("rst_osc_rstn", osc_rstn, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_spins", spins, 0);
      check("rst_wr_ready", wr_ready, 1);
      tick();

      // Weight bank writes, including bad data.
      do_write(6, 4);
      check("w6_slice", weights_flat[20:18], 3'b100);
      do_write(3, 7);
      do_write(9, 5);
      for (int k = 0; k < 8; k++) do_write($urandom_range(0, N*N-1), $urandom_range(0, 7));

      // Out-of-range address on the N=3 instance.
      w3_valid = 1'b1; w3_addr = 4'd9; w3_data = 3'd1;
      tick();
      check("n3_bad_addr_err", w3_err, 1);
      check("n3_bad_addr_bank", weights3, exp3);
      w3_addr = 4'd8; w3_data = 3'd0;
      tick();
      w3_valid = 1'b0;
      exp3[26:24] = 3'd0;
      check("n3_good_err", w3_err, 0);
      check("n3_good_bank", weights3, exp3);
      tick();

      // Basic timed run with the tie case; a write during the run must bounce.
      set_masks(4'hf, 4'h0, 4'b0101);
      exp_q.push_back(model_spins());
      tick();
      start = 1'b1;
      check("pre_osc_rstn", osc_rstn, 0);
      tick();
      t = cyc;
      start = 1'b0;
      check("rise_osc_rstn", osc_rstn, 1);
      check("run_busy", busy, 1);
      check("run_wr_ready", wr_ready, 0);
      wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 3'd0;
      tick();
      wr_valid = 1'b0;
      check("run_write_ignored", weights_flat, model_flat());
      check("run_write_no_err", wr_err, 0);
      wait_done(40, d);
      check("done_latency", d - t, S + M);
      check("decide_osc_rstn", osc_rstn, 0);
      check("decide_spins", spins, 4'b0010);
      tick();
      check("done_single", done, 0);
      check("post_busy", busy, 0);
      check("post_osc_rstn", osc_rstn, 0);

      // Abort in the second MEASURE cycle: no done, spins retained.
      set_masks(4'hf, 4'hf, 4'hf);
      start = 1'b1;
      tick();
      t = cyc;
      start = 1'b0;
      repeat (S + 1) tick();
      check("abort_in_measure", dbg_state, 2);
      seen = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_osc_rstn", osc_rstn, 0);
      check("abort_spins", spins, 4'b0010);
      repeat (20) tick();
      check("abort_no_done", done_cnt, seen);

      exp_q.push_back(model_spins());
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(40, d);
      tick();

      // Write and start in the same cycle.
      set_masks(4'h7, 4'h3, 4'h1);
      exp_q.push_back(model_spins());
      wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 3'd0;
      start = 1'b1;
      tick();
      wr_valid = 1'b0;
      start = 1'b0;
      model_w[5] = 3'd0;
      check("sw_osc_rstn", osc_rstn, 1);
      check("sw_weights", weights_flat, model_flat());
      wait_done(40, d);
      tick();

      // Start and abort together in IDLE.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_osc_rstn", osc_rstn, 0);
      tick();

      // start held high: back-to-back runs.
      set_masks(4'(($urandom_range(0, 15))), 4'(($urandom_range(0, 15))), 4'(($urandom_range(0, 15))));
      for (int k = 0; k < 3; k++) exp_q.push_back(model_spins());
      start = 1'b1;
      tick();
      t = cyc;
      wait_done(40, d0);
      wait_done(40, d1);
      wait_done(40, d2);
      start = 1'b0;
      check("held_first", d0 - t, S + M);
      check("held_gap1", d1 - d0, S + M + 1);
      check("held_gap2", d2 - d1, S + M + 1);
      tick();
      check("held_stop", busy, 0);

      // Randomized runs with interleaved writes.
      for (int r = 0; r < 6; r++) begin
         do_write($urandom_range(0, N*N-1), $urandom_range(0, 4));
         set_masks(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         exp_q.push_back(model_spins());
         start = 1'b1;
         tick();
         start = 1'b0;
         check("rand_weights_stable", weights_flat, model_flat());
         wait_done(40, d);
         tick();
      end

      // Run with nonzero result, then reset mid-MEASURE.
      set_masks(4'hf, 4'he, 4'h0);
      exp_q.push_back(model_spins());
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(40, d);
      tick();
      check("pre_rst_spins", spins, 4'b0110);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (S + 2) tick();
      check("rst_point_measure", dbg_state, 2);
      #3 rst = 1'b1;
      #1;
      for (int e = 0; e < N*N; e++) model_w[e] = 3'b010;
      check("mid_rst_weights", weights_flat, model_flat());
      check("mid_rst_osc_rstn", osc_rstn, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_spins", spins, 0);
      check("mid_rst_wr_ready", wr_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) tick();
      check("exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded, expected finish");
      $fatal(1, "timeout");
   end

endmodule
